// File: rtl/iccm_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// iccm_port_arbiter_if
//
// Purpose:
//   Bundles every signal of the ICCM port arbiter except clock and reset:
//   the boot-loader write stream, the instruction-fetch read port and the
//   single-port ICCM macro interface.
//
// Modports:
//   slave  : the arbiter's view (loader/fetch/memory-return signals in,
//            grants, read data, hold/overflow flags and memory strobes out)
//   master : the environment's view (the mirror image of slave)
//
// Signal summary:
//   prog_we_i / prog_addr_i / prog_wdata_i : loader word write, no ready
//   prog_done_i                            : end-of-image pulse
//   prog_overflow_o                        : sticky dropped-write flag
//   core_hold_o                            : hold core in reset while loading
//   fetch_req_i / fetch_addr_i             : fetch read request
//   fetch_gnt_o                            : fetch read accepted
//   fetch_rdata_o / fetch_rvalid_o         : fetch read return
//   mem_req_o / mem_we_o / mem_addr_o /
//   mem_wdata_o                            : ICCM access
//   mem_rdata_i / mem_rvalid_i             : ICCM read return (1-cycle latency)
// ----------------------------------------------------------------------------
interface iccm_port_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          prog_we_i;
    logic [AW-1:0] prog_addr_i;
    logic [DW-1:0] prog_wdata_i;
    logic          prog_done_i;
    logic          prog_overflow_o;
    logic          core_hold_o;
    logic          fetch_req_i;
    logic [AW-1:0] fetch_addr_i;
    logic          fetch_gnt_o;
    logic [DW-1:0] fetch_rdata_o;
    logic          fetch_rvalid_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_rvalid_i;

    modport slave (
        input  prog_we_i, prog_addr_i, prog_wdata_i, prog_done_i,
        input  fetch_req_i, fetch_addr_i,
        input  mem_rdata_i, mem_rvalid_i,
        output prog_overflow_o, core_hold_o,
        output fetch_gnt_o, fetch_rdata_o, fetch_rvalid_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output prog_we_i, prog_addr_i, prog_wdata_i, prog_done_i,
        output fetch_req_i, fetch_addr_i,
        output mem_rdata_i, mem_rvalid_i,
        input  prog_overflow_o, core_hold_o,
        input  fetch_gnt_o, fetch_rdata_o, fetch_rvalid_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/iccm_port_arbiter.sv
// ----------------------------------------------------------------------------
// iccm_port_arbiter
//
// Purpose:
//   Shares the single-port ICCM between the UART boot-loader write stream and
//   instruction-fetch reads. Loader writes cannot be back-pressured, so they
//   are queued in a small FIFO. One ICCM access is issued per cycle: fetch
//   reads win whenever the FIFO is empty, and otherwise once the starvation
//   counter shows STARVE_LIMIT consecutive write grants taken while a fetch
//   was waiting. A small mode FSM keeps the core held in reset while an image
//   is loaded and drained into the ICCM.
//
// Ports:
//   clock : system clock
//   reset : synchronous, active-high reset
//   bus   : iccm_port_arbiter_if.slave (loader, fetch and ICCM signals)
//
// Parameters:
//   AW           : ICCM word-address width
//   DW           : data width
//   FIFO_DEPTH   : loader write FIFO entries (power of 2, >= 2)
//   STARVE_LIMIT : max consecutive write grants while a fetch waits (>= 1)
// ----------------------------------------------------------------------------
module iccm_port_arbiter #(
    parameter int AW           = 12,
    parameter int DW           = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    iccm_port_arbiter_if.slave     bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PROG  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DW-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_rd_pend;
    logic          r_overflow;
    logic          r_hold;
    state_t        r_state;

    // ------------------------------------------------------------------
    // Arbitration and FIFO control
    // ------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_wr_req;
    logic w_rd_req;
    logic w_starved;
    logic w_rd_gnt;
    logic w_wr_gnt;
    logic w_push;
    logic w_drop;
    logic w_rvalid;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_wr_req  = !w_empty;
    assign w_rd_req  = bus.fetch_req_i;
    assign w_starved = (r_starve == SW'(STARVE_LIMIT));

    // Nothing is granted while reset is asserted, so no stale FIFO entry or
    // fetch can reach the ICCM during a mid-operation reset.
    assign w_rd_gnt = !reset && w_rd_req && (!w_wr_req || w_starved);
    assign w_wr_gnt = !reset && w_wr_req && !w_rd_gnt;

    // A full FIFO still accepts a push when the head is popped in the same
    // cycle; only a push into a full FIFO with no pop is lost.
    assign w_push = !reset && bus.prog_we_i && (!w_full || w_wr_gnt);
    assign w_drop = bus.prog_we_i && w_full && !w_wr_gnt;

    // Returns are only forwarded for reads this block actually issued.
    assign w_rvalid = !reset && bus.mem_rvalid_i && r_rd_pend;

    // ------------------------------------------------------------------
    // FIFO storage (data only, no reset needed)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= bus.prog_addr_i;
            r_fifo_data[r_wptr] <= bus.prog_wdata_i;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, starvation counter, pending read, overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_starve   <= '0;
            r_rd_pend  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_wr_gnt) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_wr_gnt})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // Counts write grants taken while a fetch is waiting; any fetch
            // grant or an idle fetch port restarts the count.
            if (w_rd_gnt || !w_rd_req) begin
                r_starve <= '0;
            end else if (w_wr_gnt && !w_starved) begin
                r_starve <= r_starve + SW'(1);
            end

            // A new grant keeps the flag set even when the previous read
            // returns in the same cycle (back-to-back reads).
            if (w_rd_gnt) begin
                r_rd_pend <= 1'b1;
            end else if (bus.mem_rvalid_i) begin
                r_rd_pend <= 1'b0;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM with registered core hold
    // ------------------------------------------------------------------
    // The hold follows the transition into PROG in the same edge, and is
    // kept for one more cycle after returning to RUN so the core is only
    // released once the ICCM is fully quiet.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_hold  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.prog_we_i) begin
                        r_state <= ST_PROG;
                        r_hold  <= 1'b1;
                    end else begin
                        r_hold  <= 1'b0;
                    end
                end
                ST_PROG: begin
                    r_hold <= 1'b1;
                    if (bus.prog_done_i) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_hold <= 1'b1;
                    if (bus.prog_we_i) begin
                        r_state <= ST_PROG;
                    end else if (w_empty && !r_rd_pend) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_hold  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.mem_req_o   = w_rd_gnt || w_wr_gnt;
        bus.mem_we_o    = w_wr_gnt;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (w_wr_gnt) begin
            bus.mem_addr_o  = r_fifo_addr[r_rptr];
            bus.mem_wdata_o = r_fifo_data[r_rptr];
        end else if (w_rd_gnt) begin
            bus.mem_addr_o  = bus.fetch_addr_i;
        end
    end

    assign bus.fetch_gnt_o     = w_rd_gnt;
    assign bus.fetch_rvalid_o  = w_rvalid;
    assign bus.fetch_rdata_o   = w_rvalid ? bus.mem_rdata_i : '0;
    assign bus.prog_overflow_o = r_overflow;
    assign bus.core_hold_o     = r_hold;

endmodule

// File: tb/tb_iccm_port_arbiter.sv
module tb_iccm_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // shared stimulus
    logic          s_we = 0, s_done = 0, s_freq = 0;
    logic [AW-1:0] s_pa = '0, s_fa = '0;
    logic [DW-1:0] s_pd = '0;
    logic          mv [2];
    logic [DW-1:0] md [2];

    iccm_port_arbiter_if #(.AW(AW), .DW(DW)) if0 ();
    iccm_port_arbiter_if #(.AW(AW), .DW(DW)) if1 ();

    iccm_port_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(8)) u_dut0 (
        .clock(clock), .reset(reset), .bus(if0.slave));
    iccm_port_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(1)) u_dut1 (
        .clock(clock), .reset(reset), .bus(if1.slave));

    assign if0.prog_we_i = s_we;   assign if1.prog_we_i = s_we;
    assign if0.prog_addr_i = s_pa; assign if1.prog_addr_i = s_pa;
    assign if0.prog_wdata_i = s_pd; assign if1.prog_wdata_i = s_pd;
    assign if0.prog_done_i = s_done; assign if1.prog_done_i = s_done;
    assign if0.fetch_req_i = s_freq; assign if1.fetch_req_i = s_freq;
    assign if0.fetch_addr_i = s_fa; assign if1.fetch_addr_i = s_fa;
    assign if0.mem_rvalid_i = mv[0]; assign if1.mem_rvalid_i = mv[1];
    assign if0.mem_rdata_i = md[0];  assign if1.mem_rdata_i = md[1];

    logic o_req [2], o_we [2], o_gnt [2], o_rv [2], o_hold [2], o_ovf [2];
    logic [AW-1:0] o_addr [2];
    logic [DW-1:0] o_wd [2], o_rd [2];
    assign o_req[0] = if0.mem_req_o;  assign o_req[1] = if1.mem_req_o;
    assign o_we[0] = if0.mem_we_o;    assign o_we[1] = if1.mem_we_o;
    assign o_gnt[0] = if0.fetch_gnt_o; assign o_gnt[1] = if1.fetch_gnt_o;
    assign o_rv[0] = if0.fetch_rvalid_o; assign o_rv[1] = if1.fetch_rvalid_o;
    assign o_hold[0] = if0.core_hold_o; assign o_hold[1] = if1.core_hold_o;
    assign o_ovf[0] = if0.prog_overflow_o; assign o_ovf[1] = if1.prog_overflow_o;
    assign o_addr[0] = if0.mem_addr_o; assign o_addr[1] = if1.mem_addr_o;
    assign o_wd[0] = if0.mem_wdata_o;  assign o_wd[1] = if1.mem_wdata_o;
    assign o_rd[0] = if0.fetch_rdata_o; assign o_rd[1] = if1.fetch_rdata_o;

    // memory environment (driven from DUT actual requests)
    logic [DW-1:0] mem [2][4096];
    logic          rv_pend [2];
    logic [DW-1:0] rv_data [2];

    // behavioural model per instance
    int            lim [2];
    logic [43:0]   mq [2][$];
    int            m_starve [2];
    logic          m_pend [2];
    int            m_mode [2];   // 0 RUN, 1 PROG, 2 DRAIN
    logic          m_hold [2], m_ovf [2], m_init [2];
    logic [43:0]   wlog [2][$];

    // sampled DUT values for literal checks
    logic c_req [2], c_we [2], c_gnt [2], c_rv [2], c_hold [2], c_ovf [2];
    logic [AW-1:0] c_addr [2];
    logic [DW-1:0] c_wd [2], c_rd [2];

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_check(input int k);
        logic w, r, rd, wr, erv;
        logic [43:0] head;
        int sz, nmode, pmode;
        c_req[k] = o_req[k]; c_we[k] = o_we[k]; c_gnt[k] = o_gnt[k];
        c_rv[k] = o_rv[k]; c_hold[k] = o_hold[k]; c_ovf[k] = o_ovf[k];
        c_addr[k] = o_addr[k]; c_wd[k] = o_wd[k]; c_rd[k] = o_rd[k];

        sz = mq[k].size();
        w = (sz > 0);
        r = s_freq;
        head = w ? mq[k][0] : 44'h0;
        rd = 1'b0; wr = 1'b0;
        if (!reset) begin
            rd = r && (!w || m_starve[k] == lim[k]);
            wr = w && !rd;
        end
        chk($sformatf("u%0d.mem_req", k), c_req[k], rd | wr);
        chk($sformatf("u%0d.fetch_gnt", k), c_gnt[k], rd);
        if (rd | wr) begin
            chk($sformatf("u%0d.mem_we", k), c_we[k], wr);
            chk($sformatf("u%0d.mem_addr", k), c_addr[k], wr ? head[43:32] : s_fa);
            if (wr) chk($sformatf("u%0d.mem_wdata", k), c_wd[k], head[31:0]);
        end
        erv = !reset && mv[k] && m_pend[k];
        chk($sformatf("u%0d.fetch_rvalid", k), c_rv[k], erv);
        chk($sformatf("u%0d.fetch_rdata", k), c_rd[k], erv ? md[k] : 32'h0);
        if (m_init[k]) begin
            chk($sformatf("u%0d.core_hold", k), c_hold[k], m_hold[k]);
            chk($sformatf("u%0d.overflow", k), c_ovf[k], m_ovf[k]);
        end

        // memory environment reacts to what the DUT actually presented
        rv_pend[k] = 1'b0;
        if (c_req[k] === 1'b1 && c_we[k] === 1'b1) begin
            mem[k][c_addr[k]] = c_wd[k];
            wlog[k].push_back({c_addr[k], c_wd[k]});
        end else if (c_req[k] === 1'b1) begin
            rv_pend[k] = 1'b1;
            rv_data[k] = mem[k][c_addr[k]];
        end

        // model next state
        if (reset) begin
            mq[k].delete();
            m_starve[k] = 0; m_pend[k] = 0; m_mode[k] = 0;
            m_hold[k] = 0; m_ovf[k] = 0; m_init[k] = 1;
        end else begin
            pmode = m_mode[k];
            nmode = pmode;
            if (pmode == 0 && s_we) nmode = 1;
            else if (pmode == 1 && s_done) nmode = 2;
            else if (pmode == 2) begin
                if (s_we) nmode = 1;
                else if (sz == 0 && !m_pend[k]) nmode = 0;
            end
            m_mode[k] = nmode;
            m_hold[k] = (nmode != 0) || (pmode != 0);
            if (wr) void'(mq[k].pop_front());
            if (s_we) begin
                if (mq[k].size() < DEPTH) mq[k].push_back({s_pa, s_pd});
                else m_ovf[k] = 1'b1;
            end
            if (rd || !r) m_starve[k] = 0;
            else if (wr && m_starve[k] < lim[k]) m_starve[k]++;
            if (rd) m_pend[k] = 1'b1;
            else if (mv[k]) m_pend[k] = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [AW-1:0] pa,
                        input logic [DW-1:0] pd, input logic dn, input logic fq,
                        input logic [AW-1:0] fa);
        @(posedge clock);
        #1;
        reset = r; s_we = we; s_pa = pa; s_pd = pd; s_done = dn; s_freq = fq; s_fa = fa;
        for (int k = 0; k < 2; k++) begin
            mv[k] = rv_pend[k];
            md[k] = rv_pend[k] ? rv_data[k] : $urandom;
            if (!rv_pend[k] && $urandom_range(0, 7) == 0) mv[k] = 1'b1;
        end
        @(negedge clock);
        for (int k = 0; k < 2; k++) model_check(k);
        cyc++;
    endtask

    task automatic idle(input int n, input logic fq);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, fq, 12'h7F0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int exp_idx [10];
        int dens, fdens;
        logic [43:0] e;
        exp_idx = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 11};
        lim[0] = 8; lim[1] = 1;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 4096; a++) mem[k][a] = {20'hA5A5A, 12'(a)};
            mem[k][16] = 32'hDEADBEEF;
            rv_pend[k] = 0; rv_data[k] = '0; mv[k] = 0; md[k] = '0;
            m_init[k] = 0; m_starve[k] = 0; m_pend[k] = 0; m_mode[k] = 0;
            m_hold[k] = 0; m_ovf[k] = 0;
        end

        // 1: reset with fetch requested, then first read
        step(1, 0, '0, '0, 0, 1, 12'h010);
        step(1, 0, '0, '0, 0, 1, 12'h010);
        for (int k = 0; k < 2; k++) begin
            chk("t1.rst_req", c_req[k], 0);
            chk("t1.rst_gnt", c_gnt[k], 0);
            chk("t1.rst_hold", c_hold[k], 0);
            chk("t1.rst_ovf", c_ovf[k], 0);
        end
        step(0, 0, '0, '0, 0, 1, 12'h010);
        chk("t1.gnt", c_gnt[0], 1);
        chk("t1.addr", c_addr[0], 12'h010);
        step(0, 0, '0, '0, 0, 0, 12'h000);
        chk("t1.rvalid", c_rv[0], 1);
        chk("t1.rdata", c_rd[0], 32'hDEADBEEF);

        // 2: short image load, drain, release
        idle(2, 0);
        step(0, 1, 12'h000, 32'h11, 0, 0, 0);
        chk("t2.nobypass", c_req[0], 0);
        chk("t2.hold_t0", c_hold[0], 0);
        step(0, 1, 12'h001, 32'h22, 0, 0, 0);
        chk("t2.we_t1", c_we[0], 1);
        chk("t2.addr_t1", c_addr[0], 12'h000);
        chk("t2.wd_t1", c_wd[0], 32'h11);
        chk("t2.hold_t1", c_hold[0], 1);
        step(0, 1, 12'h002, 32'h33, 0, 0, 0);
        chk("t2.wd_t2", c_wd[0], 32'h22);
        step(0, 0, '0, '0, 1, 0, 0);
        chk("t2.wd_t3", c_wd[0], 32'h33);
        chk("t2.addr_t3", c_addr[0], 12'h002);
        idle(1, 0);
        chk("t2.hold_t4", c_hold[0], 1);
        idle(1, 0);
        chk("t2.hold_t5", c_hold[0], 1);
        idle(1, 0);
        chk("t2.hold_t6", c_hold[0], 0);

        // 3: STARVE_LIMIT=1 instance, fetch held, 12 writes
        step(1, 0, '0, '0, 0, 0, 0);
        idle(1, 0);
        wlog[1].delete();
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 12'(12'h300 + i), 32'(32'h100 + i), 0, 1, 12'h200);
            if (i == 0 || (i % 2) == 0) chk("t3.gnt_R", c_gnt[1], 1);
            else chk("t3.gnt_W", c_we[1] & c_req[1], 1);
            if (i == 8) chk("t3.ovf_t8", c_ovf[1], 0);
            if (i == 9) chk("t3.ovf_t9", c_ovf[1], 1);
        end
        idle(10, 1);
        idle(2, 0);
        chk("t3.nwrites", wlog[1].size(), 10);
        for (int j = 0; j < 10; j++) begin
            e = {12'(12'h300 + exp_idx[j]), 32'(32'h100 + exp_idx[j])};
            if (j < wlog[1].size()) chk("t3.worder", wlog[1][j], e);
            else begin
                n_tests++; n_fail++;
                $display("FAIL t3.worder missing write %0d expected=%0h", j, e);
            end
        end
        chk("t3.ovf_sticky", c_ovf[1], 1);

        // 4: STARVE_LIMIT=8 instance, continuous writes with fetch waiting
        step(1, 0, '0, '0, 0, 0, 0);
        idle(1, 0);
        step(0, 1, 12'h400, 32'h4000, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 12'(12'h401 + i), 32'(32'h4001 + i), 0, 1, 12'h040);
            if (i < 8) begin
                chk("t4.wgrant", c_we[0] & c_req[0], 1);
                chk("t4.nognt", c_gnt[0], 0);
            end else if (i == 8) chk("t4.fgrant", c_gnt[0], 1);
            else chk("t4.after", c_we[0] & c_req[0], 1);
        end
        idle(6, 0);

        // 5: reset right after the end-of-image pulse
        step(1, 0, '0, '0, 0, 0, 0);
        idle(1, 0);
        step(0, 1, 12'h500, 32'h5000, 0, 1, 12'h050);
        step(0, 1, 12'h501, 32'h5001, 1, 1, 12'h050);
        step(1, 0, '0, '0, 0, 0, 0);
        wlog[0].delete(); wlog[1].delete();
        idle(4, 0);
        for (int k = 0; k < 2; k++) begin
            chk("t5.nwrites", wlog[k].size(), 0);
            chk("t5.hold", c_hold[k], 0);
            chk("t5.ovf", c_ovf[k], 0);
        end

        // 6: back-to-back reads in RUN
        step(0, 0, '0, '0, 0, 1, 12'h100);
        chk("t6.gnt0", c_gnt[0], 1);
        step(0, 0, '0, '0, 0, 1, 12'h101);
        chk("t6.gnt1", c_gnt[0], 1);
        chk("t6.rv0", c_rv[0], 1);
        chk("t6.rd0", c_rd[0], 32'hA5A5A100);
        step(0, 0, '0, '0, 0, 0, 0);
        chk("t6.rv1", c_rv[0], 1);
        chk("t6.rd1", c_rd[0], 32'hA5A5A101);

        // randomized phase
        dens = 50; fdens = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                dens = $urandom_range(0, 3) * 33 + 1;
                fdens = $urandom_range(0, 4) * 25;
            end
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 99) < dens),
                 12'($urandom), $urandom,
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 99) < fdens),
                 12'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/iccm_port_arbiter.md
Name: iccm_port_arbiter

Overview:
- Shares the single-port ICCM (instr_mem_top) between two requesters: the UART boot-loader write stream from iccm_controller, and instruction-fetch reads from the TL-UL SRAM adapter.
- The loader cannot be back-pressured, so its writes are buffered in a small FIFO.
- A mode FSM holds the core (core_hold_o) while an image is being loaded and drained.
- A starvation counter guarantees that fetch reads make forward progress.

Parameters:
AW, 12, ICCM word-address width
DW, 32, data width
FIFO_DEPTH, 4, loader write FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, max consecutive write grants while fetch waits (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
prog_we_i  in  1  loader write strobe, one word per pulse, no ready
prog_addr_i  in  AW  loader word address
prog_wdata_i  in  DW  loader write data
prog_done_i  in  1  end-of-image pulse
prog_overflow_o  out  1  sticky: loader write dropped
core_hold_o  out  1  hold core in reset (feeds rstmgr)
fetch_req_i  in  1  read request from SRAM adapter
fetch_addr_i  in  AW  read word address
fetch_gnt_o  out  1  read accepted this cycle
fetch_rdata_o  out  DW  read data
fetch_rvalid_o  out  1  read data valid
mem_req_o  out  1  ICCM access strobe
mem_we_o  out  1  ICCM write enable
mem_addr_o  out  AW  ICCM address
mem_wdata_o  out  DW  ICCM write data
mem_rdata_i  in  DW  ICCM read data
mem_rvalid_i  in  1  ICCM read valid, exactly 1 cycle after read issue

Behaviour:
- Reset values: state=RUN, FIFO empty, rd_pend=0, starve_cnt=0, prog_overflow_o=0, core_hold_o=0. While reset is high, mem_req_o, fetch_gnt_o and fetch_rvalid_o are 0.
- FIFO push: prog_we_i=1 pushes {addr,data}.
  - If full and no pop this cycle, the write is dropped and prog_overflow_o sets (cleared only by reset).
  - Full with a pop in the same cycle: push accepted.
  - No bypass path: the earliest mem write is 1 cycle after prog_we_i.
- Arbitration (combinational, one access per cycle):
  - W = FIFO non-empty; R = fetch_req_i.
  - Grant fetch if R and (!W or starve_cnt==STARVE_LIMIT). Otherwise grant write if W.
- Write grant: mem_req_o=1, mem_we_o=1, FIFO head on mem_addr_o/mem_wdata_o, pop.
- Read grant: mem_req_o=1, mem_we_o=0, mem_addr_o=fetch_addr_i, fetch_gnt_o=1, rd_pend<=1. With no grant, mem_req_o=0.
- starve_cnt:
  - Increments on a write grant while R=1.
  - Clears on a fetch grant or when R=0.
  - Saturates at STARVE_LIMIT.
- Read return: fetch_rvalid_o = mem_rvalid_i & rd_pend. fetch_rdata_o = mem_rdata_i when fetch_rvalid_o=1, else 0. mem_rvalid_i with rd_pend=0 is ignored.
- rd_pend is set on a read grant and cleared on a return. Back-to-back reads are allowed, one per cycle.
- FSM states:
  - RUN: prog_we_i -> PROG. prog_done_i is ignored.
  - PROG: prog_done_i -> DRAIN. A push in the same cycle is still enqueued.
  - DRAIN: prog_we_i -> PROG. FIFO empty and rd_pend=0 -> RUN.
- core_hold_o is registered: 1 in PROG and DRAIN, so it rises the cycle after the first write and falls the cycle after RUN is entered.
- Fetch reads are served in all states under the same arbitration.
- Reset mid-operation: FIFO contents are discarded (never written), pending read is dropped, FSM returns to RUN.

Test Plan:
1. Reset held 2 cycles with fetch_req_i=1 -> mem_req_o=0, fetch_gnt_o=0, all outputs 0. First cycle after release: read of 0x010 granted; next cycle fetch_rvalid_o=1, fetch_rdata_o=0xDEADBEEF (memory model).
2. Loader writes (0x000,0x11),(0x001,0x22),(0x002,0x33) on consecutive cycles t0..t2, then prog_done_i at t3 -> mem writes at t1,t2,t3 in order; core_hold_o=1 from t1; DRAIN at t4, RUN at t5; core_hold_o=0 at t6.
3. STARVE_LIMIT=1, FIFO_DEPTH=4, fetch_req_i held, 12 writes w0..w11 at t0..t11 -> grants alternate W,R from t1; w8 and w10 dropped; exactly 10 mem writes (w0..w7, w9, w11) in order; prog_overflow_o=1 from t9 and sticky.
4. Default STARVE_LIMIT=8, continuous writes, fetch_req_i asserted at t0 -> 8 write grants, then fetch_gnt_o=1 at t8; starve_cnt=0 at t9.
5. Two writes queued, prog_done_i pulsed with the last write, reset asserted in the next cycle -> state=RUN, core_hold_o=0, FIFO empty, no further mem_we_o, prog_overflow_o=0.
6. RUN mode, no writes, reads 0x100 and 0x101 on consecutive cycles -> fetch_gnt_o=1 both cycles, fetch_rvalid_o=1 one cycle after each with the matching data.
